// File: rtl/dispense_timer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dispense_timer_arbiter
//  Purpose  : Shares one countdown timer among the three dispenser stages
//             (motor A, B, C). A stage holds its request; the arbiter grants
//             the timer, counts that stage's duration and pulses its DONE.
//  Ports    : clk1_i   - system clock, rising edge
//             reset_i  - synchronous active-high reset
//             req_i    - [0]=A [1]=B [2]=C level requests, held by requester
//             abort_i  - cancels the current timing run
//             gnt_o    - one-hot grant, zero when idle
//             done_o   - one-cycle pulse per stage at terminal count
//             busy_o   - high whenever a run (or its finish cycle) is active
//             count_o  - remaining count of the active run
//  Config   : TARB_FIXED_PRIO_EN defined -> fixed priority A > B > C;
//             undefined (default)        -> round-robin arbitration.
//  Revision : 1.0 - initial release
// ============================================================================
module dispense_timer_arbiter #(
   parameter int CNT_W = 3,
   parameter int DUR_A = 5,
   parameter int DUR_B = 3,
   parameter int DUR_C = 7
) (
   input  logic             clk1_i,
   input  logic             reset_i,
   input  logic [2:0]       req_i,
   input  logic             abort_i,
   output logic [2:0]       gnt_o,
   output logic [2:0]       done_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int             c_DUR_MAX = (1 << CNT_W) - 1;
   localparam logic [CNT_W-1:0] c_DUR_A = CNT_W'(DUR_A);
   localparam logic [CNT_W-1:0] c_DUR_B = CNT_W'(DUR_B);
   localparam logic [CNT_W-1:0] c_DUR_C = CNT_W'(DUR_C);

   // Durations must fit the counter and be non-zero, otherwise a run could
   // never reach its terminal count of 1.
   generate
      if (DUR_A < 1 || DUR_A > c_DUR_MAX) begin : g_bad_dur_a
         $error("DUR_A out of range 1..2^CNT_W-1");
      end
      if (DUR_B < 1 || DUR_B > c_DUR_MAX) begin : g_bad_dur_b
         $error("DUR_B out of range 1..2^CNT_W-1");
      end
      if (DUR_C < 1 || DUR_C > c_DUR_MAX) begin : g_bad_dur_c
         $error("DUR_C out of range 1..2^CNT_W-1");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         gnt_q, gnt_d;
   logic [2:0]         done_q, done_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [1:0]         win_w;
   logic [CNT_W-1:0]   dur_w;

`ifdef TARB_FIXED_PRIO_EN
   // Lowest set request bit wins.
   always_comb begin
      win_w = 2'd2;
      if (req_i[0])      win_w = 2'd0;
      else if (req_i[1]) win_w = 2'd1;
   end
`else
   logic [1:0] rr_ptr_q, rr_ptr_d;

   // Search starts one past the last winner, so the last winner is
   // considered only after the other two stages.
   always_comb begin
      win_w = 2'd2;
      unique case (rr_ptr_q)
         2'd0: begin
            if (req_i[1])      win_w = 2'd1;
            else if (req_i[2]) win_w = 2'd2;
            else               win_w = 2'd0;
         end
         2'd1: begin
            if (req_i[2])      win_w = 2'd2;
            else if (req_i[0]) win_w = 2'd0;
            else               win_w = 2'd1;
         end
         default: begin
            if (req_i[0])      win_w = 2'd0;
            else if (req_i[1]) win_w = 2'd1;
            else               win_w = 2'd2;
         end
      endcase
   end
`endif

   always_comb begin
      unique case (win_w)
         2'd0:    dur_w = c_DUR_A;
         2'd1:    dur_w = c_DUR_B;
         default: dur_w = c_DUR_C;
      endcase
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      done_d  = 3'b000;
      count_d = count_q;
`ifndef TARB_FIXED_PRIO_EN
      rr_ptr_d = rr_ptr_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            gnt_d   = 3'b000;
            count_d = '0;
            if (|req_i) begin
               state_d = S_RUN;
               gnt_d   = 3'b001 << win_w;
               count_d = dur_w;
`ifndef TARB_FIXED_PRIO_EN
               rr_ptr_d = win_w;
`endif
            end
         end
         S_RUN: begin
            // Abort and a dropped request both beat the terminal count.
            if (abort_i || ((req_i & gnt_q) == 3'b000)) begin
               state_d = S_IDLE;
               gnt_d   = 3'b000;
               count_d = '0;
            end else if (count_q <= CNT_W'(1)) begin
               // Treating 0 as terminal too keeps the counter from ever wrapping.
               state_d = S_FIN;
               count_d = '0;
               done_d  = gnt_q;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            gnt_d   = 3'b000;
            count_d = '0;
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = 3'b000;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk1_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         gnt_q   <= 3'b000;
         done_q  <= 3'b000;
         count_q <= '0;
`ifndef TARB_FIXED_PRIO_EN
         rr_ptr_q <= 2'd2;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         count_q <= count_d;
`ifndef TARB_FIXED_PRIO_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

   assign gnt_o   = gnt_q;
   assign done_o  = done_q;
   assign count_o = count_q;
   assign busy_o  = (state_q != S_IDLE);

endmodule
`default_nettype wire
